// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// Instruction fetch stage. Owns the program counter. Reads one word per cycle
// from a combinational instruction memory and loads it into the IF/ID
// pipeline register. Handles stalls from decode, redirects from branches and
// jumps, and halt instructions.
//
// Ports
//   clk          in   clock; every state update happens on the rising edge
//   rst          in   synchronous active-low reset
//   mem_read     out  read enable to instruction memory (high only in FETCH)
//   addr         out  word address to instruction memory (always the PC)
//   instr_in     in   combinational read data for addr
//   stall        in   decode cannot accept an instruction this cycle
//   redirect     in   taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc  in   redirect target, reduced modulo MAX_LINE_LENGTH
//   id_valid     out  IF/ID register holds a valid instruction
//   id_instr     out  IF/ID instruction word
//   id_pc        out  address id_instr was fetched from
//   halted       out  fetch is stopped on a halt instruction
//   fetch_count  out  instructions delivered to decode, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int          ISIZE           = 16,
    parameter int          DSIZE           = 16,
    parameter int          MAX_LINE_LENGTH = 256,
    parameter logic [3:0]  HALT_OPCODE     = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_read,
    output logic [ISIZE-1:0] addr,
    input  logic [DSIZE-1:0] instr_in,
    input  logic             stall,
    input  logic             redirect,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             id_valid,
    output logic [DSIZE-1:0] id_instr,
    output logic [ISIZE-1:0] id_pc,
    output logic             halted,
    output logic [15:0]      fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // One bit wider than the PC so MAX_LINE_LENGTH = 2**ISIZE is representable.
    localparam logic [ISIZE:0]   MAX_LEN = (ISIZE + 1)'(MAX_LINE_LENGTH);
    localparam logic [ISIZE-1:0] PC_LAST = ISIZE'(MAX_LINE_LENGTH - 1);

    logic [1:0]       state_reg, state_next;
    logic [ISIZE-1:0] pc_reg, pc_next;
    logic             id_valid_reg, id_valid_next;
    logic [DSIZE-1:0] id_instr_reg, id_instr_next;
    logic [ISIZE-1:0] id_pc_reg, id_pc_next;
    logic [15:0]      count_reg, count_next;

    logic [ISIZE-1:0] pc_inc;
    logic [ISIZE-1:0] redirect_target;
    logic             is_halt;

    // The >= also pulls an out-of-range PC back to 0 instead of running on.
    assign pc_inc          = (pc_reg >= PC_LAST) ? '0 : pc_reg + 1'b1;
    // Power-of-two MAX_LINE_LENGTH reduces to a simple bit mask here.
    assign redirect_target = ISIZE'({1'b0, redirect_pc} % MAX_LEN);
    assign is_halt         = (instr_in[DSIZE-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        id_valid_next = id_valid_reg;
        id_instr_next = id_instr_reg;
        id_pc_next    = id_pc_reg;
        count_next    = count_reg;

        case (state_reg)
            ST_IDLE: begin
                // Redirect is deliberately ignored while idle.
                state_next = ST_FETCH;
            end
            ST_FETCH, ST_HALT: begin
                if (redirect) begin
                    // Redirect beats stall and halt; leaves one bubble behind.
                    state_next    = ST_FETCH;
                    pc_next       = redirect_target;
                    id_valid_next = 1'b0;
                end else if (!stall) begin
                    if (state_reg == ST_FETCH) begin
                        id_instr_next = instr_in;
                        id_pc_next    = pc_reg;
                        id_valid_next = 1'b1;
                        count_next    = (count_reg == 16'hFFFF) ? count_reg
                                                                : count_reg + 16'd1;
                        // A halt word is still delivered, but the PC parks on it.
                        if (is_halt) begin
                            state_next = ST_HALT;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end else begin
                        // Halted and decode has consumed the last word.
                        id_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            id_valid_reg <= 1'b0;
            id_instr_reg <= '0;
            id_pc_reg    <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            id_valid_reg <= id_valid_next;
            id_instr_reg <= id_instr_next;
            id_pc_reg    <= id_pc_next;
            count_reg    <= count_next;
        end
    end

    assign mem_read    = (state_reg == ST_FETCH);
    assign halted      = (state_reg == ST_HALT);
    assign addr        = pc_reg;
    assign id_valid    = id_valid_reg;
    assign id_instr    = id_instr_reg;
    assign id_pc       = id_pc_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Bench for instr_fetch_stage with the default parameters. A 256-word memory
// model answers addr combinationally. A table of per-cycle stimulus and
// expected post-edge outputs is pushed into a scoreboard queue as each row is
// driven and compared one edge later. A hand-written run then checks the PC
// wrap from 255 to 0 with periodic stalls.
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic [15:0] addr;
    logic [15:0] instr_in;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        mem_read;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] idpc;
        logic [15:0] instr;
        logic        halted;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [15:0] idpc;
        logic [15:0] instr;
    } deliv_t;

    vec_t   vecs[$];
    vec_t   exp_q[$];
    deliv_t dq[$];

    instr_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .addr        (addr),
        .instr_in    (instr_in),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    assign instr_in = mem[addr[7:0]];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // rst stall redirect rpc | mem_read addr valid id_pc id_instr halted count
    task automatic add(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                       input logic mr, input logic [15:0] a, input logic v,
                       input logic [15:0] ip, input logic [15:0] ins,
                       input logic h, input logic [15:0] c);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rpc;
        t.mem_read = mr; t.addr = a; t.valid = v; t.idpc = ip;
        t.instr = ins; t.halted = h; t.cnt = c;
        vecs.push_back(t);
    endtask

    initial begin
        vec_t   e;
        deliv_t d;
        logic [15:0] pc_exp;

        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003;
        mem[3] = 16'h1004; mem[4] = 16'h1005; mem[5] = 16'hF000;

        // Reset, then straight-line fetch of words 0..2
        add(0,0,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);
        add(0,0,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);
        add(1,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);  // IDLE cycle
        add(1,0,0,16'h0000, 1,16'h0001, 1,16'h0000,16'h1001, 0,16'd1);
        add(1,0,0,16'h0000, 1,16'h0002, 1,16'h0001,16'h1002, 0,16'd2);
        add(1,0,0,16'h0000, 1,16'h0003, 1,16'h0002,16'h1003, 0,16'd3);
        // Three stall cycles with id_pc=2: everything frozen
        add(1,1,0,16'h0000, 1,16'h0003, 1,16'h0002,16'h1003, 0,16'd3);
        add(1,1,0,16'h0000, 1,16'h0003, 1,16'h0002,16'h1003, 0,16'd3);
        add(1,1,0,16'h0000, 1,16'h0003, 1,16'h0002,16'h1003, 0,16'd3);
        add(1,0,0,16'h0000, 1,16'h0004, 1,16'h0003,16'h1004, 0,16'd4);
        add(1,0,0,16'h0000, 1,16'h0005, 1,16'h0004,16'h1005, 0,16'd5);
        // Halt word at 5: delivered, PC parks at 5
        add(1,0,0,16'h0000, 0,16'h0005, 1,16'h0005,16'hF000, 1,16'd6);
        add(1,1,0,16'h0000, 0,16'h0005, 1,16'h0005,16'hF000, 1,16'd6);  // stall holds IF/ID
        add(1,0,0,16'h0000, 0,16'h0005, 0,16'h0005,16'hF000, 1,16'd6);
        add(1,0,0,16'h0000, 0,16'h0005, 0,16'h0005,16'hF000, 1,16'd6);
        // Redirect to 0 leaves HALT
        add(1,0,1,16'h0000, 1,16'h0000, 0,16'h0005,16'hF000, 0,16'd6);
        add(1,0,0,16'h0000, 1,16'h0001, 1,16'h0000,16'h1001, 0,16'd7);
        add(1,0,0,16'h0000, 1,16'h0002, 1,16'h0001,16'h1002, 0,16'd8);
        // Redirect with stall in the same cycle: bubble then 0x40
        add(1,1,1,16'h0040, 1,16'h0040, 0,16'h0001,16'h1002, 0,16'd8);
        add(1,0,0,16'h0000, 1,16'h0041, 1,16'h0040,16'h2040, 0,16'd9);
        // Out-of-range target 0x110 reduces to 0x10
        add(1,0,1,16'h0110, 1,16'h0010, 0,16'h0040,16'h2040, 0,16'd9);
        add(1,0,0,16'h0000, 1,16'h0011, 1,16'h0010,16'h2010, 0,16'd10);
        // Reset coincident with stall and redirect wins
        add(0,1,1,16'h0040, 0,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);
        // Redirect during IDLE is ignored
        add(1,0,1,16'h0040, 1,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);
        add(1,0,0,16'h0000, 1,16'h0001, 1,16'h0000,16'h1001, 0,16'd1);
        // Into HALT again, then a one-cycle reset
        add(1,0,1,16'h0005, 1,16'h0005, 0,16'h0000,16'h1001, 0,16'd1);
        add(1,0,0,16'h0000, 0,16'h0005, 1,16'h0005,16'hF000, 1,16'd2);
        add(0,0,0,16'h0000, 0,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);
        add(1,0,0,16'h0000, 1,16'h0000, 0,16'h0000,16'h0000, 0,16'd0);
        add(1,0,0,16'h0000, 1,16'h0001, 1,16'h0000,16'h1001, 0,16'd1);

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; stall = vecs[k].stall;
            redirect = vecs[k].redirect; redirect_pc = vecs[k].rpc;
            exp_q.push_back(vecs[k]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("txn %0d: mem_read=%0b addr=%h id_valid=%0b id_pc=%h id_instr=%h halted=%0b count=%0d",
                     k, mem_read, addr, id_valid, id_pc, id_instr, halted, fetch_count);
            chk($sformatf("row%0d mem_read", k), 16'(mem_read), 16'(e.mem_read));
            chk($sformatf("row%0d addr", k),     addr,           e.addr);
            chk($sformatf("row%0d id_valid", k), 16'(id_valid),  16'(e.valid));
            chk($sformatf("row%0d id_pc", k),    id_pc,          e.idpc);
            chk($sformatf("row%0d id_instr", k), id_instr,       e.instr);
            chk($sformatf("row%0d halted", k),   16'(halted),    16'(e.halted));
            chk($sformatf("row%0d count", k),    fetch_count,    e.cnt);
        end

        // Wrap run: redirect to 250, then fetch with a stall every third cycle.
        @(negedge clk);
        stall = 1'b0; redirect = 1'b1; redirect_pc = 16'd250;
        @(posedge clk);
        #1;
        chk("wrap redirect addr", addr, 16'd250);
        pc_exp = 16'd250;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            stall = (k % 3 == 2);
            if (!stall) begin
                d.idpc = pc_exp; d.instr = mem[pc_exp[7:0]];
                dq.push_back(d);
                pc_exp = (pc_exp == 16'd255) ? 16'd0 : pc_exp + 16'd1;
            end
            @(posedge clk);
            #1;
            $display("txn wrap%0d: stall=%0b id_valid=%0b id_pc=%h id_instr=%h addr=%h",
                     k, stall, id_valid, id_pc, id_instr, addr);
            if (dq.size() != 0) begin
                d = dq.pop_front();
                chk($sformatf("wrap%0d id_valid", k), 16'(id_valid), 16'd1);
                chk($sformatf("wrap%0d id_pc", k),    id_pc,         d.idpc);
                chk($sformatf("wrap%0d id_instr", k), id_instr,      d.instr);
            end
            chk($sformatf("wrap%0d addr", k), addr, pc_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter ISIZE, default 16, instruction-memory address width (PC width).
REQ-002 Parameter DSIZE, default 16, instruction word width.
REQ-003 Parameter MAX_LINE_LENGTH, default 256, number of words in instruction memory; PC wraps at this bound.
REQ-004 Parameter HALT_OPCODE, default 4'hF, value of instr[DSIZE-1:DSIZE-4] that marks a halt instruction.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-007 mem_read  output  1  read enable to instruction memory.
REQ-008 addr  output  ISIZE  word address to instruction memory; always equals current PC.
REQ-009 instr_in  input  DSIZE  combinational read data from instruction memory, valid in the same cycle as addr.
REQ-010 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-011 redirect  input  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-012 redirect_pc  input  ISIZE  target word address for redirect.
REQ-013 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-014 id_instr  output  DSIZE  registered instruction for decode.
REQ-015 id_pc  output  ISIZE  address id_instr was fetched from.
REQ-016 halted  output  1  fetch is stopped on a halt instruction.
REQ-017 fetch_count  output  16  number of instructions delivered to decode, saturating.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, HALT; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-019 mem_read SHALL be 1 only in FETCH; addr SHALL equal PC in every state.
REQ-020 FETCH, stall=0, redirect=0: at the edge, id_instr<=instr_in, id_pc<=PC, id_valid<=1, PC<=PC+1, fetch_count increments; latency addr-to-id_instr is one cycle.
REQ-021 PC increment SHALL wrap: PC=MAX_LINE_LENGTH-1 advances to 0; redirect_pc >= MAX_LINE_LENGTH SHALL be reduced modulo MAX_LINE_LENGTH.
REQ-022 FETCH, stall=1, redirect=0: PC, id_instr, id_pc, id_valid, fetch_count SHALL hold.
REQ-023 redirect=1 in any non-IDLE state SHALL take priority over stall and halt: at the edge PC<=redirect_pc, id_valid<=0 (one bubble), id_instr/id_pc hold, state<=FETCH, fetch_count unchanged.
REQ-024 redirect in IDLE SHALL be ignored.
REQ-025 A fetch accepted per REQ-020 whose instr_in[DSIZE-1:DSIZE-4]==HALT_OPCODE SHALL be delivered normally, PC SHALL NOT advance, and state SHALL go to HALT.
REQ-026 In HALT: mem_read=0, halted=1, PC holds; if stall=0, id_valid<=0 at the next edge; if stall=1, IF/ID holds; only redirect or reset exits HALT.
REQ-027 halted SHALL be 1 exactly while state is HALT.
REQ-028 fetch_count SHALL saturate at 16'hFFFF.

Reset
REQ-029 While rst=0 at a rising edge: PC<=0, state<=IDLE, id_valid<=0, id_instr<=0, id_pc<=0, fetch_count<=0, halted=0, mem_read=0.
REQ-030 Reset asserted mid-stall, mid-halt or coincident with redirect SHALL win over all other inputs.

Verification
REQ-031 Reset then memory words 0..3 = 16'h1001,16'h1002,16'h1003,16'h1004, no stall: id_instr sequence 1001..1004 with id_pc 0..3 on consecutive cycles starting 2 cycles after reset release; fetch_count=4 after the fourth.
REQ-032 stall=1 for 3 cycles while id_pc=2: id_instr/id_pc/id_valid/fetch_count frozen for 3 cycles; next delivered id_pc=3, no instruction dropped or duplicated.
REQ-033 redirect=1, redirect_pc=8'h40, with stall=1 in the same cycle: next cycle id_valid=0, following cycle id_pc=16'h40.
REQ-034 Word 5 = 16'hF000: delivered with id_pc=5, then halted=1, mem_read=0, id_valid=0, PC stays 6-1=5; a redirect to 0 restarts fetch at 0.
REQ-035 Sequential run through address 255 (MAX_LINE_LENGTH=256): id_pc 255 followed by id_pc 0.
REQ-036 rst=0 asserted for one cycle during HALT: next cycle state IDLE, all outputs at reset values, fetch resumes from address 0.
